// File: rtl/adc128s_pkg.sv
// Shared constants and helpers for the ADC128S SPI-slave converter model.
package adc128s_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;

  typedef enum logic [2:0] {
    CH_LD_LFT  = 3'd0,
    CH_LD_RGHT = 3'd4,
    CH_STEER   = 3'd5,
    CH_BATT    = 3'd6
  } chnl_e;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [DATA_W-1:0]  sample_t;

  function automatic frame_t tx_word(input sample_t value);
    return {4'h0, value};
  endfunction

endpackage

// File: rtl/adc128s_fc_if.sv
// SPI bus between the A2D master and the ADC128S slave model.
interface adc128s_fc_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_spi_slv.sv
// SPI slave datapath: input synchronisers, edge detect, 16-bit shift registers
// and a saturating bit counter. Loads load_word at SS_n fall.
module adc128s_spi_slv
  import adc128s_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  adc128s_fc_if.slave  spi,
  input  frame_t       load_word,
  output frame_t       rx_word,
  output logic         frame_done
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_W);

  logic ss_s1, ss_s2, ss_s3;
  logic sclk_s1, sclk_s2, sclk_s3;
  logic mosi_s1, mosi_s2;
  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  frame_t     tx_shft, rx_shft;
  logic [4:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_s3   <= 1'b1;
      sclk_s1 <= 1'b1;
      sclk_s2 <= 1'b1;
      sclk_s3 <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      ss_s1   <= spi.SS_n;
      ss_s2   <= ss_s1;
      ss_s3   <= ss_s2;
      sclk_s1 <= spi.SCLK;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      mosi_s1 <= spi.MOSI;
      mosi_s2 <= mosi_s1;
    end
  end

  assign ss_fall   =  ss_s3   & ~ss_s2;
  assign ss_rise   = ~ss_s3   &  ss_s2;
  assign sclk_rise = ~sclk_s3 &  sclk_s2;
  assign sclk_fall =  sclk_s3 & ~sclk_s2;

  // The leading SCLK fall before the first rise must not shift, hence bit_cnt != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '0;
      rx_shft <= '0;
      bit_cnt <= '0;
    end else if (ss_fall) begin
      tx_shft <= load_word;
      rx_shft <= '0;
      bit_cnt <= '0;
    end else if (!ss_s2) begin
      if (sclk_rise) begin
        rx_shft <= {rx_shft[FRAME_W-2:0], mosi_s2};
        if (bit_cnt != CNT_FULL)
          bit_cnt <= bit_cnt + 5'd1;
      end
      if (sclk_fall && (bit_cnt != '0))
        tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
    end
  end

  assign rx_word    = rx_shft;
  assign frame_done = ss_rise && (bit_cnt == CNT_FULL);
  assign spi.MISO   = ss_s2 ? 1'b0 : tx_shft[FRAME_W-1];

endmodule

// File: rtl/adc128s_fc.sv
// ADC128S 8-channel 12-bit A2D model (SPI slave). Result in frame N is for the
// channel addressed in frame N-1. Optional macro: ADC128S_CHNL_TAG_EN.
module adc128s_fc
  import adc128s_pkg::*;
#(
  parameter logic [11:0] UNUSED_VAL = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  adc128s_fc_if.slave spi,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic [2:0] pend_chnl;
  sample_t    sel_val;
  frame_t     rx_word;
  logic       frame_done;
  logic       unused_rx;

  always_comb begin
    sel_val = UNUSED_VAL;
    case (pend_chnl)
      CH_LD_LFT:  sel_val = ld_cell_lft;
      CH_LD_RGHT: sel_val = ld_cell_rght;
      CH_STEER:   sel_val = steerPot;
      CH_BATT:    sel_val = batt;
`ifdef ADC128S_CHNL_TAG_EN
      default:    sel_val = {pend_chnl, 9'h000};
`else
      default:    sel_val = UNUSED_VAL;
`endif
    endcase
  end

  // Aborted frames never assert frame_done, so the pending channel survives them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pend_chnl <= '0;
    else if (frame_done)
      pend_chnl <= rx_word[13:11];
  end

  assign unused_rx = ^{rx_word[15:14], rx_word[10:0]};

  adc128s_spi_slv u_spi (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (spi),
    .load_word  (tx_word(sel_val)),
    .rx_word    (rx_word),
    .frame_done (frame_done)
  );

endmodule

// File: tb/tb_adc128s_fc.sv
// Scoreboard bench for adc128s_fc: frames push expected MISO words, a monitor
// captures MISO on SCLK rises and compares at SS_n rise.
module tb_adc128s_fc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] ld_cell_lft  = 12'h3A5;
  logic [11:0] ld_cell_rght = 12'h7FF;
  logic [11:0] steerPot     = 12'h800;
  logic [11:0] batt         = 12'hFFF;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] cap = '0;
  int nbits = 0;

`ifdef ADC128S_CHNL_TAG_EN
  localparam logic [15:0] EXP_CH2 = 16'h0400;
  localparam logic [15:0] EXP_CH7 = 16'h0E00;
`else
  localparam logic [15:0] EXP_CH2 = 16'h0000;
  localparam logic [15:0] EXP_CH7 = 16'h0000;
`endif

  adc128s_fc_if spi_bus ();

  adc128s_fc #(.UNUSED_VAL(12'h000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi_bus),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge spi_bus.SS_n) begin
    cap   = '0;
    nbits = 0;
  end

  always @(posedge spi_bus.SCLK) begin
    if (!spi_bus.SS_n && rst_n) begin
      cap = {cap[14:0], spi_bus.MISO};
      nbits++;
    end
  end

  always @(posedge spi_bus.SS_n) begin
    if (nbits == 16) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame actual=%h expected=none", cap);
      end else begin
        check("miso_word", cap, exp_q.pop_front());
      end
    end
  end

  task automatic frame(input logic [2:0] ch, input int nb, input logic [15:0] exp,
                       input bit push, input bit raise);
    logic [15:0] word;
    word = {2'b00, ch, 11'h000};
    if (push) exp_q.push_back(exp);
    @(negedge clk) spi_bus.SS_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      spi_bus.SCLK = 1'b0;
      spi_bus.MOSI = word[15-i];
      repeat (6) @(negedge clk);
      spi_bus.SCLK = 1'b1;
      repeat (6) @(negedge clk);
    end
    if (raise) begin
      spi_bus.SS_n = 1'b1;
      spi_bus.MOSI = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    spi_bus.SS_n = 1'b1;
    spi_bus.SCLK = 1'b1;
    spi_bus.MOSI = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("reset_miso", {15'd0, spi_bus.MISO}, 16'h0000);
    check("reset_pend", {13'd0, dut.pend_chnl}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);

    frame(3'd4, 16, 16'h03A5, 1, 1);
    check("pend_after_f1", {13'd0, dut.pend_chnl}, 16'h0004);
    frame(3'd5, 16, 16'h07FF, 1, 1);
    frame(3'd6, 16, 16'h0800, 1, 1);
    check("pend_after_f3", {13'd0, dut.pend_chnl}, 16'h0006);

    fork
      frame(3'd2, 16, 16'h0FFF, 1, 1);
      begin
        repeat (60) @(negedge clk);
        batt = 12'h123;
      end
    join
    frame(3'd0, 16, EXP_CH2, 1, 1);
    check("pend_after_ch2_read", {13'd0, dut.pend_chnl}, 16'h0000);
    frame(3'd6, 16, 16'h03A5, 1, 1);

    frame(3'd4, 8, 16'h0000, 0, 1);
    check("pend_after_abort", {13'd0, dut.pend_chnl}, 16'h0006);
    frame(3'd5, 16, 16'h0123, 1, 1);

    frame(3'd3, 5, 16'h0000, 0, 0);
    check("miso_before_reset", {15'd0, spi_bus.MISO}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("miso_mid_reset", {15'd0, spi_bus.MISO}, 16'h0000);
    check("pend_mid_reset", {13'd0, dut.pend_chnl}, 16'h0000);
    spi_bus.SS_n = 1'b1;
    spi_bus.SCLK = 1'b1;
    spi_bus.MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    frame(3'd7, 16, 16'h03A5, 1, 1);
    frame(3'd0, 16, EXP_CH7, 1, 1);
    check("pend_final", {13'd0, dut.pend_chnl}, 16'h0000);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc128s_fc.md
Name: adc128s_fc

Overview:
- Behavioural-synthesizable model of the ADC128S 8-channel, 12-bit A2D converter, acting as an SPI slave to the Segway's A2D interface.
- Returns load-cell left/right, steering-pot and battery readings over a 16-bit SPI frame.
- Sits in the top-level bench between the Segway DUT's A2D_* pins and the stimulus values.

Parameters:
- UNUSED_VAL, 12'h000, conversion result returned for channels 1, 2, 3, 7.

Ports:
- clk  input  1  system clock; all logic runs on clk rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  SPI slave select, active low.
- SCLK  input  1  SPI serial clock, idles high.
- MOSI  input  1  SPI data from master.
- MISO  output  1  SPI data to master.
- ld_cell_lft  input  12  channel 0 value.
- ld_cell_rght  input  12  channel 4 value.
- steerPot  input  12  channel 5 value.
- batt  input  12  channel 6 value.

Behaviour:
- Synchronisation
  - SS_n, SCLK, MOSI each pass through a 2-flop synchroniser on clk.
  - SS_n and SCLK flops reset to 1; MOSI flops reset to 0.
  - A third flop on SCLK and SS_n provides edge detection: sclk_rise, sclk_fall, ss_fall, ss_rise.
- Frame format: 16 bits, MSB first.
  - MOSI word: {2'b00, chnl[2:0], 11'h000}.
  - MISO word: {4'h0, result[11:0]}.
- Pipelined response: the result in frame N is for the channel addressed in frame N-1.
  - Register pend_chnl resets to 3'd0, so the first frame after reset returns channel 0.
- ss_fall:
  - Select the value for pend_chnl (0→ld_cell_lft, 4→ld_cell_rght, 5→steerPot, 6→batt, else UNUSED_VAL).
  - Load tx_shft <= {4'h0, value}.
  - Clear bit counter and rx_shft.
  - Input values are sampled only at this instant; changes during a frame do not affect that frame.
- sclk_rise with SS_n low: rx_shft <= {rx_shft[14:0], MOSI_sync}; bit counter increments; the counter saturates at 16.
- sclk_fall with SS_n low and bit counter ≥1: tx_shft <= {tx_shft[14:0], 1'b0}.
  - The leading fall (before the first rise) does not shift.
- MISO = tx_shft[15] while synchronised SS_n is low; 1'b0 while high.
- ss_rise:
  - If bit counter == 16, pend_chnl <= rx_shft[13:11].
  - Otherwise (aborted frame) pend_chnl is unchanged.
- SCLK edges while SS_n high are ignored.
- Reset at any time (including mid-frame) clears:
  - tx_shft, rx_shft and bit counter to 0
  - pend_chnl to 0
  - MISO to 0
- Frames may be issued back-to-back with ≥1 clk of SS_n high between them.
- Latency: MISO bit 15 is valid 3 clk after the SS_n fall (synchroniser plus edge detect).
  - The master must hold SCLK high ≥4 clk after SS_n falls.
  - SCLK half-period must be ≥4 clk.

Optional Feature:
- Macro ADC128S_CHNL_TAG_EN.
- Defined: unused channels (1, 2, 3, 7) return {chnl[2:0], 9'h000} instead of UNUSED_VAL, so mis-addressing is visible.
- Undefined: they return UNUSED_VAL.
- Used channels are identical in both builds.

Decomposition:
- Package adc128s_pkg holds:
  - channel constants CH_LD_LFT=3'd0, CH_LD_RGHT=3'd4, CH_STEER=3'd5, CH_BATT=3'd6
  - FRAME_W=16, DATA_W=12
- One sub-module, adc128s_spi_slv, holds the synchronisers, edge detect, shift registers and bit counter.
  - It presents the received 16-bit word and a frame_done strobe (16 bits received).
  - It accepts a 16-bit load word at ss_fall.
- The top module holds pend_chnl and the channel mux.

Test Plan:
- Reset, then one frame sending chnl 4, with ld_cell_lft=12'h3A5 → MISO word 16'h03A5; pend_chnl becomes 4.
- Second frame sending chnl 5, with ld_cell_rght=12'h7FF → MISO word 16'h07FF; third frame with steerPot=12'h800 → 16'h0800.
- Frame sending chnl 6, then next frame with batt=12'hFFF → 16'h0FFF; change batt to 12'h123 mid-frame → the frame still returns 16'h0FFF.
- Address chnl 2, then read → 16'h0000 with the macro undefined; 16'h0400 with ADC128S_CHNL_TAG_EN defined.
- Abort a frame after 8 SCLK rises (SS_n raised) → pend_chnl unchanged; the next full frame returns the previously addressed channel.
- Assert rst_n low mid-frame (after 5 bits) → MISO=0 and pend_chnl=0 immediately; the next frame returns ld_cell_lft.
